// File: rtl/kmac_sca_sequencer.sv
// kmac_sca_sequencer - drives one masked SHA3 hash per trigger on the KMAC SCA core.
// Moore FSM: reseed, message injection, start/process pulses, digest capture and unmasking.
module kmac_sca_sequencer #(
  parameter int MsgLen        = 128,
  parameter int NumShares     = 2,
  parameter int DigestW       = 256,
  parameter int TimeoutCycles = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           trig_i,
  input  logic [NumShares*MsgLen-1:0]    msg_shares_i,
  input  logic                           clear_i,
  output logic                           entropy_refresh_req_o,
  input  logic [3:0]                     entropy_configured_i,
  output logic                           start_o,
  output logic [NumShares*MsgLen-1:0]    msg_o,
  output logic                           msg_valid_o,
  input  logic                           msg_ready_i,
  output logic                           process_o,
  input  logic [3:0]                     absorbed_i,
  input  logic                           state_valid_i,
  input  logic [NumShares*DigestW-1:0]   state_i,
  output logic [3:0]                     done_o,
  input  logic                           err_i,
  output logic [DigestW-1:0]             digest_o,
  output logic                           digest_valid_o,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam logic [3:0] MuBi4True  = 4'h6;
  localparam logic [3:0] MuBi4False = 4'h9;
  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

  typedef enum logic [3:0] {
    StIdle,
    StReseed,
    StWaitEnt,
    StStart,
    StMsg,
    StProcess,
    StWaitAbs,
    StDone,
    StError
  } state_e;

  state_e                        state_q, state_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic [NumShares*MsgLen-1:0]   msg_q, msg_d;
  logic [DigestW-1:0]            digest_q, digest_d;
  logic                          digest_valid_q, digest_valid_d;
  logic [DigestW-1:0]            state_xor;
  logic                          timeout;

  always_comb begin
    state_xor = '0;
    for (int k = 0; k < NumShares; k++) begin
      state_xor = state_xor ^ state_i[k*DigestW +: DigestW];
    end
  end

  assign timeout = (cnt_q == CntMax);

  always_comb begin
    state_d        = state_q;
    cnt_d          = '0;
    msg_d          = msg_q;
    digest_d       = digest_q;
    digest_valid_d = digest_valid_q;

    // A core error overrides every other transition, including digest capture.
    if (err_i && (state_q != StError)) begin
      state_d = StError;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trig_i) begin
            msg_d          = msg_shares_i;
            digest_valid_d = 1'b0;
            state_d        = StReseed;
          end
        end
        StReseed: state_d = StWaitEnt;
        StWaitEnt: begin
          cnt_d = cnt_q + CntW'(1);
          if (entropy_configured_i == MuBi4True) begin
            state_d = StStart;
          end else if (entropy_configured_i != MuBi4False) begin
            state_d = StError;
          end else if (timeout) begin
            state_d = StError;
          end
        end
        StStart: state_d = StMsg;
        StMsg: begin
          cnt_d = cnt_q + CntW'(1);
          if (msg_ready_i) begin
            state_d = StProcess;
          end else if (timeout) begin
            state_d = StError;
          end
        end
        StProcess: state_d = StWaitAbs;
        StWaitAbs: begin
          cnt_d = cnt_q + CntW'(1);
          if (absorbed_i == MuBi4True) begin
            if (state_valid_i) begin
              digest_d       = state_xor;
              digest_valid_d = 1'b1;
              state_d        = StDone;
            end else begin
              state_d = StError;
            end
          end else if (absorbed_i != MuBi4False) begin
            state_d = StError;
          end else if (timeout) begin
            state_d = StError;
          end
        end
        StDone: state_d = StIdle;
        StError: begin
          if (clear_i) begin
            digest_d       = '0;
            digest_valid_d = 1'b0;
            state_d        = StIdle;
          end
        end
        default: state_d = StError;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      msg_q          <= '0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      msg_q          <= msg_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
    end
  end

  assign entropy_refresh_req_o = (state_q == StReseed);
  assign start_o               = (state_q == StStart);
  assign msg_valid_o           = (state_q == StMsg);
  assign process_o             = (state_q == StProcess);
  assign done_o                = (state_q == StDone) ? MuBi4True : MuBi4False;
  assign busy_o                = (state_q != StIdle) && (state_q != StError);
  assign err_o                 = (state_q == StError);
  assign msg_o                 = msg_q;
  assign digest_o              = digest_q;
  assign digest_valid_o        = digest_valid_q;

endmodule

// File: tb/tb_kmac_sca_sequencer.sv
// tb/tb_kmac_sca_sequencer.sv - self-checking bench for kmac_sca_sequencer.
// Scenario table plus random scenarios checked cycle by cycle against a timeline model.
module tb_kmac_sca_sequencer;
  localparam int MsgLen = 128;
  localparam int NumShares = 2;
  localparam int DigestW = 256;
  localparam int TimeoutCycles = 1024;
  localparam logic [3:0] MT = 4'h6;
  localparam logic [3:0] MF = 4'h9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic trig_i = 1'b0, clear_i = 1'b0, msg_ready_i = 1'b0, state_valid_i = 1'b0, err_i = 1'b0;
  logic [255:0] msg_shares_i = '0;
  logic [3:0] entropy_configured_i = MF, absorbed_i = MF;
  logic [511:0] state_i = '0;
  logic entropy_refresh_req_o, start_o, msg_valid_o, process_o, digest_valid_o, busy_o, err_o;
  logic [255:0] msg_o, digest_o;
  logic [3:0] done_o;

  kmac_sca_sequencer #(
    .MsgLen(MsgLen), .NumShares(NumShares), .DigestW(DigestW), .TimeoutCycles(TimeoutCycles)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .trig_i(trig_i), .msg_shares_i(msg_shares_i), .clear_i(clear_i),
    .entropy_refresh_req_o(entropy_refresh_req_o), .entropy_configured_i(entropy_configured_i),
    .start_o(start_o), .msg_o(msg_o), .msg_valid_o(msg_valid_o), .msg_ready_i(msg_ready_i),
    .process_o(process_o), .absorbed_i(absorbed_i), .state_valid_i(state_valid_i),
    .state_i(state_i), .done_o(done_o), .err_i(err_i), .digest_o(digest_o),
    .digest_valid_o(digest_valid_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [255:0] model_dig = '0;
  logic model_dv = 1'b0;

  // kind: 0 nominal, 1 state_valid low at absorb, 2 absorbed invalid, 3 entropy invalid, 4 err_i pulse at cycle k
  typedef struct {
    int kind;
    int e;
    int r;
    int a;
    int k;
    logic [255:0] msg;
  } scn_t;

  scn_t tbl[20];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [6:0] ctl();
    return {entropy_refresh_req_o, start_o, msg_valid_o, process_o, busy_o, err_o, digest_valid_o};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    trig_i = 0; clear_i = 0; err_i = 0; msg_ready_i = 0; state_valid_i = 0;
    entropy_configured_i = MF; absorbed_i = MF;
  endtask

  task automatic run_scn(input int idx, input scn_t s);
    int ent_c, ready_c, abs_c, done_c, err_c, clr_c, last_c;
    logic past_err;
    logic [255:0] new_dig;
    logic [6:0] exp_ctl;
    new_dig = '0;
    ent_c = 2 + s.e;
    ready_c = 4 + s.e + s.r;
    abs_c = 6 + s.e + s.r + s.a;
    done_c = abs_c + 1;
    case (s.kind)
      0: err_c = 1 << 30;
      1, 2: err_c = done_c;
      3: err_c = ent_c + 1;
      default: err_c = s.k + 1;
    endcase
    clr_c = err_c + 2;
    last_c = (s.kind == 0) ? done_c + 1 : clr_c + 1;
    for (int c = 0; c <= last_c; c++) begin
      trig_i = (c == 0) || (c < last_c && $urandom_range(0, 3) == 0);
      msg_shares_i = (c == 0) ? s.msg : rnd256();
      entropy_configured_i = (c < ent_c) ? MF : ((s.kind == 3) ? 4'h3 : MT);
      msg_ready_i = (c >= ready_c);
      absorbed_i = (c == abs_c) ? ((s.kind == 2) ? 4'hA : MT) : MF;
      state_valid_i = (c == abs_c) ? (s.kind != 1) : 1'($urandom_range(0, 1));
      state_i = {rnd256(), rnd256()};
      if (c == abs_c) new_dig = state_i[255:0] ^ state_i[511:256];
      err_i = (s.kind == 4) && (c == s.k);
      clear_i = (c < err_c) ? 1'($urandom_range(0, 1)) : (c == clr_c);

      past_err = (c >= err_c);
      if (c == 1) model_dv = 1'b0;
      if (c == done_c && !past_err) begin
        model_dv = 1'b1;
        model_dig = new_dig;
      end
      if (s.kind != 0 && c == clr_c + 1) begin
        model_dv = 1'b0;
        model_dig = '0;
      end
      exp_ctl = {!past_err && c == 1,
                 !past_err && c == ent_c + 1,
                 !past_err && c >= ent_c + 2 && c <= ready_c,
                 !past_err && c == ready_c + 1,
                 !past_err && c >= 1 && c <= done_c,
                 past_err && c <= clr_c,
                 model_dv};
      chk($sformatf("s%0d c%0d ctl", idx, c), 256'(ctl()), 256'(exp_ctl));
      chk($sformatf("s%0d c%0d done", idx, c), 256'(done_o),
          256'((!past_err && c == done_c) ? MT : MF));
      chk($sformatf("s%0d c%0d digest", idx, c), digest_o, model_dig);
      if (c >= 1) chk($sformatf("s%0d c%0d msg", idx, c), msg_o, s.msg);
      step();
    end
    idle_inputs();
  endtask

  initial begin
    logic [127:0] m, rr;
    logic [255:0] d;
    int refr;
    scn_t s;
    idle_inputs();
    #2;
    chk("reset ctl", 256'(ctl()), 256'(0));
    chk("reset done", 256'(done_o), 256'(MF));
    chk("reset digest", digest_o, 256'(0));
    chk("reset msg", msg_o, 256'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    m = 128'h00112233445566778899AABBCCDDEEFF;
    rr = {$urandom(), $urandom(), $urandom(), $urandom()};
    tbl[0] = '{kind: 0, e: 0, r: 0, a: 20, k: 0, msg: {m ^ rr, rr}};
    tbl[1] = '{kind: 0, e: 0, r: 7, a: 3, k: 0, msg: rnd256()};
    tbl[2] = '{kind: 1, e: 1, r: 0, a: 2, k: 0, msg: rnd256()};
    tbl[3] = '{kind: 2, e: 0, r: 1, a: 4, k: 0, msg: rnd256()};
    tbl[4] = '{kind: 4, e: 0, r: 3, a: 2, k: 5, msg: rnd256()};
    tbl[5] = '{kind: 3, e: 2, r: 0, a: 0, k: 0, msg: rnd256()};
    tbl[6] = '{kind: 0, e: 3, r: 2, a: 0, k: 0, msg: rnd256()};
    tbl[7] = '{kind: 4, e: 1, r: 1, a: 3, k: 11, msg: rnd256()};
    for (int i = 8; i < 20; i++) begin
      tbl[i].kind = $urandom_range(0, 4);
      tbl[i].e = $urandom_range(0, 4);
      tbl[i].r = $urandom_range(0, 4);
      tbl[i].a = $urandom_range(0, 15);
      tbl[i].k = $urandom_range(1, 6 + tbl[i].e + tbl[i].r + tbl[i].a);
      tbl[i].msg = rnd256();
    end
    for (int i = 0; i < 20; i++) run_scn(i, tbl[i]);

    // Timeout in WaitAbs: absorbed_i stays False.
    for (int c = 0; c <= 1031; c++) begin
      trig_i = (c == 0);
      entropy_configured_i = MT;
      msg_ready_i = 1'b1;
      absorbed_i = MF;
      if (c == 6) chk("tmo enter busy", 256'(busy_o), 256'(1));
      if (c == 1029) chk("tmo last wait", 256'({busy_o, err_o}), 256'(2'b10));
      if (c == 1030) chk("tmo error", 256'({busy_o, err_o}), 256'(2'b01));
      step();
    end
    idle_inputs();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    model_dig = '0;
    model_dv = 1'b0;
    chk("tmo clear ctl", 256'(ctl()), 256'(0));
    chk("tmo clear digest", digest_o, 256'(0));

    // trig_i held high: one reseed per Idle visit.
    refr = 0;
    d = '0;
    for (int c = 0; c <= 10; c++) begin
      trig_i = (c <= 9);
      err_i = (c == 9);
      entropy_configured_i = MT;
      msg_ready_i = 1'b1;
      absorbed_i = (c == 6) ? MT : MF;
      state_valid_i = 1'b1;
      state_i = {rnd256(), rnd256()};
      if (c == 6) d = state_i[255:0] ^ state_i[511:256];
      if (c >= 1 && c <= 8) refr += int'(entropy_refresh_req_o);
      if (c == 7) begin
        chk("hold done", 256'(done_o), 256'(MT));
        chk("hold digest", digest_o, d);
      end
      if (c == 8) chk("hold idle dv", 256'({busy_o, digest_valid_o}), 256'(2'b01));
      if (c == 9) chk("hold second reseed", 256'(entropy_refresh_req_o), 256'(1));
      if (c == 10) chk("hold err", 256'(err_o), 256'(1));
      step();
    end
    chk("hold reseed count", 256'(refr), 256'(1));
    idle_inputs();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    model_dig = '0;
    model_dv = 1'b0;
    chk("hold clear", 256'({ctl(), digest_o}), 256'(0));

    // Asynchronous reset while in WaitAbs.
    s = '{kind: 0, e: 0, r: 0, a: 4, k: 0, msg: rnd256()};
    for (int c = 0; c < 8; c++) begin
      trig_i = (c == 0);
      msg_shares_i = s.msg;
      entropy_configured_i = MT;
      msg_ready_i = 1'b1;
      absorbed_i = MF;
      step();
    end
    chk("pre-reset busy", 256'(busy_o), 256'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset ctl", 256'(ctl()), 256'(0));
    chk("async reset done", 256'(done_o), 256'(MF));
    chk("async reset msg", msg_o, 256'(0));
    idle_inputs();
    step();
    rst_n = 1'b1;
    step();
    model_dig = '0;
    model_dv = 1'b0;
    run_scn(99, s);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kmac_sca_sequencer.md
# kmac_sca_sequencer

Control sequencer that sits directly upstream of the reduced KMAC/SHA3 SCA core and drives one complete masked SHA3 hash per trigger. The sequence is: reseed the PRNG, inject the pre-masked message, start, process, wait for absorption, capture and unmask the digest, release the core. It replaces the bench- or host-driven pulse sequence on start/process/done. This keeps capture timing deterministic for side-channel campaigns.

## Interface
- MsgLen, 128, message width per share
- NumShares, 2, number of shares (1 or 2)
- DigestW, 256, digest bits taken from the low end of each state share
- TimeoutCycles, 1024, cycle limit for each wait state
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous active-low reset
- trig_i  in  1  hash request; sampled only in Idle
- msg_shares_i  in  NumShares*MsgLen  pre-masked message, share k at [k*MsgLen +: MsgLen]
- clear_i  in  1  leave Error and clear the digest
- entropy_refresh_req_o  out  1  PRNG reseed pulse to core
- entropy_configured_i  in  4  mubi4 from core
- start_o  out  1  start pulse to core
- msg_o  out  NumShares*MsgLen  registered message shares to core
- msg_valid_o  out  1  message valid to core
- msg_ready_i  in  1  message ready from core
- process_o  out  1  process pulse to core
- absorbed_i  in  4  mubi4 from core
- state_valid_i  in  1  state valid from core
- state_i  in  NumShares*DigestW  low DigestW bits of each state share
- done_o  out  4  mubi4 to core
- err_i  in  1  aggregated core error
- digest_o  out  DigestW  unmasked digest
- digest_valid_o  out  1  digest valid
- busy_o  out  1  sequence in progress
- err_o  out  1  sequencer in Error

## Operation
- Moore FSM with states Idle, Reseed, WaitEnt, Start, Msg, Process, WaitAbs, Done, Error. All core-facing controls decode from the registered state.
- Idle, trig_i=1: latch msg_shares_i into msg_o, clear digest_valid_o, go to Reseed.
- Reseed: 1 cycle with entropy_refresh_req_o=1, then go to WaitEnt.
- WaitEnt: exits to Start when entropy_configured_i==MuBi4True.
- Start: 1 cycle with start_o=1, then go to Msg.
- Msg: msg_valid_o=1. On msg_valid_o&msg_ready_i, go to Process.
- Process: 1 cycle with process_o=1, then go to WaitAbs.
- WaitAbs: waits for absorbed_i==MuBi4True.
  - If state_valid_i=1 in that cycle: digest_o <= XOR over shares of state_i, then go to Done.
  - If state_valid_i=0 in that cycle: go to Error.
- Done: 1 cycle with done_o=MuBi4True and digest_valid_o set (level), then go to Idle.
- done_o=MuBi4False in every state except Done.
- Mubi checks:
  - absorbed_i not in {True, False} while in WaitAbs: go to Error.
  - entropy_configured_i not in {True, False} while in WaitEnt: go to Error.
- Timeout: a counter of width $clog2(TimeoutCycles+1) clears on entry to WaitEnt, Msg and WaitAbs. If it reaches TimeoutCycles-1 without exit: go to Error.
- err_i=1 in any state other than Error: go to Error next cycle. This takes priority over all other transitions.
- Error: err_o=1, every control output inactive, msg_valid_o=0. Stays until clear_i=1, then goes to Idle with digest_o=0 and digest_valid_o=0.
- trig_i outside Idle is ignored, not queued. clear_i outside Error is ignored.
- busy_o=1 in every state except Idle and Error.

## Timing
- Reset values: state Idle, all outputs 0, done_o=MuBi4False, digest_o=0, msg_o=0.
- trig_i at cycle T gives entropy_refresh_req_o at T+1. With entropy configured on arrival, start_o is at T+3.
- msg_valid_o rises the cycle after start_o. It holds with msg_o stable until accepted.
- The acceptance at cycle H gives process_o at H+1.
- absorbed_i=True at cycle A gives done_o=True and digest_valid_o=1 from A+1. digest_valid_o holds until the next accepted trig_i, or until clear.
- Best-case trig-to-done is 6 cycles plus the core latency.
- Asynchronous reset mid-sequence: immediate return to reset values. No pulse completes.

## Test plan
- Nominal: msg shares {M^R, R} with M=128'h0011..EEFF, configured mubi=True at T+2, ready at once, absorbed+state_valid 20 cycles later with S0^S1=D -> pulses at T+1, T+3, T+5; digest_o=D, digest_valid_o=1, done_o=True for 1 cycle.
- Backpressure: msg_ready_i low for 7 cycles -> msg_valid_o high 8 cycles with msg_o constant; process_o exactly 1 cycle after the handshake.
- Timeout: absorbed_i held False -> Error after 1024 cycles in WaitAbs, err_o=1, busy_o=0; clear_i -> Idle, digest_valid_o=0.
- Faults:
  - absorbed_i=4'hA in WaitAbs -> Error next cycle.
  - err_i pulse in Msg -> Error, msg_valid_o=0.
- trig_i held high across a whole sequence -> exactly one reseed pulse per Idle visit. A second sequence starts only after Done.
- rst_ni asserted in WaitAbs -> all outputs at reset values immediately; a new trig_i afterwards completes normally.
